// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads opcode (and immediate for two-byte opcodes)
// over a byte-wide req/ack memory port and loads a registered decode slot.
// Optional feature macro: FETCH_STATS_EN (adds saturating stat counters).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   pc_in                       current PC from the PC unit
//   flush                       redirect; kills in-flight and buffered work
//   imem_req/addr/rdata/ack     instruction-memory byte port
//   fetch_stall                 low only in the advance cycle
//   instr_fetched               opcode delivered on advance, else op_q
//   id_valid/ready              decode slot handshake
//   id_instr/imm/two_byte/pc    decode slot payload
//   stat_instr, stat_flush      advance / flush counters (FETCH_STATS_EN only)
module fetch_unit #(
  parameter logic [3:0] OPCODE_2B = 4'hC
`ifdef FETCH_STATS_EN
  , parameter int unsigned STAT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pc_in,
  input  logic       flush,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       imem_ack,
  output logic       fetch_stall,
  output logic [7:0] instr_fetched,
  output logic       id_valid,
  input  logic       id_ready,
  output logic [7:0] id_instr,
  output logic [7:0] id_imm,
  output logic       id_two_byte,
  output logic [7:0] id_pc
`ifdef FETCH_STATS_EN
  , output logic [STAT_W-1:0] stat_instr
  , output logic [STAT_W-1:0] stat_flush
`endif
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_IMM  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] imm;
    logic          two_byte;
    logic [AW-1:0] pc;
  } slot_t;

  state_t        state_q, state_d;
  logic [DW-1:0] op_q, op_d;
  logic [DW-1:0] imm_q, imm_d;
  slot_t         slot_q, slot_d;
  logic          id_valid_q, id_valid_d;

  logic          advance;
  logic          slot_free;
  logic          hold_two;
  slot_t         new_slot;

  // State register and decode slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OP;
      op_q       <= '0;
      imm_q      <= '0;
      slot_q     <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      slot_q     <= slot_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Next-state, memory port and slot-load logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    slot_d     = slot_q;
    id_valid_d = id_valid_q;
    imem_req   = 1'b0;
    imem_addr  = pc_in;
    advance    = 1'b0;
    new_slot   = '0;
    slot_free  = !id_valid_q || id_ready;
    hold_two   = (op_q[7:4] == OPCODE_2B);

    case (state_q)
      S_OP: begin
        imem_req  = 1'b1;
        imem_addr = pc_in;
        if (imem_ack) begin
          if (imem_rdata[7:4] == OPCODE_2B) begin
            op_d    = imem_rdata;
            state_d = S_IMM;
          end else if (slot_free) begin
            advance  = 1'b1;
            new_slot = '{instr: imem_rdata, imm: '0, two_byte: 1'b0, pc: pc_in};
          end else begin
            op_d    = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_IMM: begin
        imem_req  = 1'b1;
        imem_addr = pc_in + AW'(1);
        if (imem_ack) begin
          imm_d = imem_rdata;
          if (slot_free) begin
            advance  = 1'b1;
            new_slot = '{instr: op_q, imm: imem_rdata, two_byte: 1'b1, pc: pc_in};
            state_d  = S_OP;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // imm_q may be stale when a one-byte opcode is parked here
        if (slot_free) begin
          advance  = 1'b1;
          new_slot = '{instr: op_q, imm: hold_two ? imm_q : DW'(0),
                       two_byte: hold_two, pc: pc_in};
          state_d  = S_OP;
        end
      end
      default: state_d = S_OP;
    endcase

    // Flush overrides everything, including an ack in the same cycle
    if (flush) begin
      advance  = 1'b0;
      imem_req = 1'b0;
      state_d  = S_OP;
      op_d     = op_q;
      imm_d    = imm_q;
    end

    if (advance) begin
      slot_d     = new_slot;
      id_valid_d = 1'b1;
    end else if (flush || id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  assign fetch_stall   = !advance;
  assign instr_fetched = advance ? new_slot.instr : op_q;
  assign id_valid      = id_valid_q;
  assign id_instr      = slot_q.instr;
  assign id_imm        = slot_q.imm;
  assign id_two_byte   = slot_q.two_byte;
  assign id_pc         = slot_q.pc;

`ifdef FETCH_STATS_EN
  logic [STAT_W-1:0] stat_instr_q, stat_instr_d;
  logic [STAT_W-1:0] stat_flush_q, stat_flush_d;

  // Saturating event counters
  always_comb begin
    stat_instr_d = stat_instr_q;
    stat_flush_d = stat_flush_q;
    if (advance && (stat_instr_q != '1)) stat_instr_d = stat_instr_q + STAT_W'(1);
    if (flush && (stat_flush_q != '1))   stat_flush_d = stat_flush_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_instr_q <= '0;
      stat_flush_q <= '0;
    end else begin
      stat_instr_q <= stat_instr_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign stat_instr = stat_instr_q;
  assign stat_flush = stat_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// backpressure / flush / async-reset sequences, then randomized traffic
// checked against an instruction-stream model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc_in;
  logic       flush;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ack;
  logic       fetch_stall;
  logic [7:0] instr_fetched;
  logic       id_valid;
  logic       id_ready;
  logic [7:0] id_instr;
  logic [7:0] id_imm;
  logic       id_two_byte;
  logic [7:0] id_pc;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_instr;
  logic [15:0] stat_flush;
`endif

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc_in),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .fetch_stall  (fetch_stall),
    .instr_fetched(instr_fetched),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_imm       (id_imm),
    .id_two_byte  (id_two_byte),
    .id_pc        (id_pc)
`ifdef FETCH_STATS_EN
    , .stat_instr (stat_instr)
    , .stat_flush (stat_flush)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Move to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] pc;
    logic [7:0] b0;
    logic [7:0] b1;
    int         waits;
    logic [7:0] e_instr;
    logic [7:0] e_imm;
    logic       e_two;
    logic [7:0] e_addr2;
  } vec_t;

  vec_t vecs[5];

  // Random-phase model state
  logic [7:0] mem[256];
  logic [7:0] m_pc;
  int         m_got;
  int         m_len;
  logic       m_valid;
  logic [7:0] m_instr, m_imm, m_pc_slot;
  logic       m_two;
  int         wait_cnt;
  int         adv_cnt, fl_cnt;
  logic       fl, rdy, acc, exp_adv, exp_req, sfree;

  initial begin
    vecs[0] = '{8'h10, 8'h35, 8'h00, 1, 8'h35, 8'h00, 1'b0, 8'h11};
    vecs[1] = '{8'h20, 8'hC1, 8'h7F, 0, 8'hC1, 8'h7F, 1'b1, 8'h21};
    vecs[2] = '{8'hFF, 8'hC2, 8'h11, 2, 8'hC2, 8'h11, 1'b1, 8'h00};
    vecs[3] = '{8'h33, 8'hBC, 8'h00, 0, 8'hBC, 8'h00, 1'b0, 8'h34};
    vecs[4] = '{8'h7E, 8'hCF, 8'hC0, 3, 8'hCF, 8'hC0, 1'b1, 8'h7F};

    rst_n = 1'b0; pc_in = 8'h00; flush = 1'b0; imem_ack = 1'b0;
    imem_rdata = 8'h00; id_ready = 1'b1;
    step();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", 32'(id_instr), 32'd0);
    chk("rst_id_imm",   32'(id_imm),   32'd0);
    chk("rst_id_pc",    32'(id_pc),    32'd0);
    chk("rst_two",      32'(id_two_byte), 32'd0);
    chk("rst_stall",    32'(fetch_stall), 32'd1);
    step();
    rst_n = 1'b1;

    // Directed single-instruction table, decode always ready
    for (int i = 0; i < 5; i++) begin
      pc_in = vecs[i].pc; id_ready = 1'b1; flush = 1'b0; imem_ack = 1'b0;
      #1;
      chk("vec_req",  32'(imem_req),  32'd1);
      chk("vec_addr", 32'(imem_addr), 32'(vecs[i].pc));
      for (int w = 0; w < vecs[i].waits; w++) begin
        step();
        chk("vec_wait_stall", 32'(fetch_stall), 32'd1);
        chk("vec_wait_addr",  32'(imem_addr), 32'(vecs[i].pc));
      end
      imem_rdata = vecs[i].b0; imem_ack = 1'b1;
      #1;
      if (vecs[i].e_two) begin
        chk("vec_op_stall", 32'(fetch_stall), 32'd1);
        step();
        imem_rdata = vecs[i].b1; imem_ack = 1'b1;
        #1;
        chk("vec_req2",  32'(imem_req),  32'd1);
        chk("vec_addr2", 32'(imem_addr), 32'(vecs[i].e_addr2));
      end
      chk("vec_adv_stall", 32'(fetch_stall), 32'd0);
      chk("vec_instr_fetched", 32'(instr_fetched), 32'(vecs[i].e_instr));
      step();
      imem_ack = 1'b0;
      #1;
      chk("vec_id_valid", 32'(id_valid),    32'd1);
      chk("vec_id_instr", 32'(id_instr),    32'(vecs[i].e_instr));
      chk("vec_id_imm",   32'(id_imm),      32'(vecs[i].e_imm));
      chk("vec_id_two",   32'(id_two_byte), 32'(vecs[i].e_two));
      chk("vec_id_pc",    32'(id_pc),       32'(vecs[i].pc));
      step();
    end

    // Backpressure: slot busy when next opcode arrives
    id_ready = 1'b0; pc_in = 8'h40; imem_rdata = 8'h05; imem_ack = 1'b1;
    #1; chk("bp_first_adv", 32'(fetch_stall), 32'd0);
    step();
    pc_in = 8'h41; imem_rdata = 8'h21; imem_ack = 1'b1;
    #1; chk("bp_ack_stall", 32'(fetch_stall), 32'd1);
    step();
    imem_ack = 1'b0;
    #1;
    chk("bp_hold_req",   32'(imem_req),    32'd0);
    chk("bp_hold_stall", 32'(fetch_stall), 32'd1);
    chk("bp_hold_slot",  32'(id_instr),    32'h05);
    chk("bp_hold_valid", 32'(id_valid),    32'd1);
    step();
    id_ready = 1'b1;
    #1;
    chk("bp_release_stall", 32'(fetch_stall),   32'd0);
    chk("bp_release_instr", 32'(instr_fetched), 32'h21);
    step();
    id_ready = 1'b0;
    #1;
    chk("bp_slot_instr", 32'(id_instr), 32'h21);
    chk("bp_slot_pc",    32'(id_pc),    32'h41);

    // Flush in S_IMM with a simultaneous ack, slot occupied
    pc_in = 8'h42; imem_rdata = 8'hC4; imem_ack = 1'b1;
    #1; chk("fl_op_stall", 32'(fetch_stall), 32'd1);
    step();
    flush = 1'b1; imem_rdata = 8'h99; imem_ack = 1'b1;
    #1;
    chk("fl_req",   32'(imem_req),    32'd0);
    chk("fl_stall", 32'(fetch_stall), 32'd1);
    step();
    flush = 1'b0; imem_ack = 1'b0; pc_in = 8'h80;
    #1;
    chk("fl_id_valid", 32'(id_valid),  32'd0);
    chk("fl_req_new",  32'(imem_req),  32'd1);
    chk("fl_addr_new", 32'(imem_addr), 32'h80);

    // Async reset while in S_IMM with the slot full
    id_ready = 1'b0; imem_rdata = 8'h06; imem_ack = 1'b1;
    step();
    pc_in = 8'h81; imem_rdata = 8'hC3; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    #1;
    chk("ar_imm_addr",  32'(imem_addr), 32'h82);
    chk("ar_pre_valid", 32'(id_valid),  32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid",  32'(id_valid), 32'd0);
    chk("ar_instr",  32'(id_instr), 32'd0);
    chk("ar_pc",     32'(id_pc),    32'd0);
    step();
    rst_n = 1'b1; pc_in = 8'h90;
    #1;
    chk("ar_req",   32'(imem_req),    32'd1);
    chk("ar_addr",  32'(imem_addr),   32'h90);
    chk("ar_stall", 32'(fetch_stall), 32'd1);
`ifdef FETCH_STATS_EN
    chk("ar_stat_instr", 32'(stat_instr), 32'd0);
    chk("ar_stat_flush", 32'(stat_flush), 32'd0);
`endif

    // Randomized traffic vs. instruction-stream model
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(2) == 0) b[7:4] = 4'hC;
      mem[i] = b;
    end
    m_pc = 8'($urandom); m_got = 0; m_valid = 1'b0;
    m_instr = '0; m_imm = '0; m_two = 1'b0; m_pc_slot = '0;
    wait_cnt = 0; adv_cnt = 0; fl_cnt = 0;

    for (int n = 0; n < 3000; n++) begin
      step();
      chk("rnd_id_valid", 32'(id_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_id_instr", 32'(id_instr),    32'(m_instr));
        chk("rnd_id_imm",   32'(id_imm),      32'(m_imm));
        chk("rnd_id_two",   32'(id_two_byte), 32'(m_two));
        chk("rnd_id_pc",    32'(id_pc),       32'(m_pc_slot));
      end
      fl  = ($urandom_range(15) == 0);
      rdy = ($urandom_range(2) != 0);
      flush = fl; id_ready = rdy; pc_in = m_pc; imem_ack = 1'b0;
      m_len = (mem[m_pc][7:4] == 4'hC) ? 2 : 1;
      #1;
      exp_req = !fl && (m_got < m_len);
      chk("rnd_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) chk("rnd_addr", 32'(imem_addr), 32'(8'(m_pc + 8'(m_got))));
      if ((imem_req && wait_cnt == 0) || (fl && $urandom_range(1) == 1)) begin
        imem_ack = 1'b1;
        imem_rdata = mem[imem_addr];
        wait_cnt = $urandom_range(2);
      end else if (imem_req) begin
        wait_cnt--;
        imem_rdata = 8'($urandom);
      end
      #1;
      acc = imem_ack && imem_req;
      sfree = !m_valid || rdy;
      exp_adv = !fl && sfree && ((m_got + (acc ? 1 : 0)) >= m_len);
      chk("rnd_stall", 32'(fetch_stall), 32'(!exp_adv));
      if (exp_adv) chk("rnd_instr_fetched", 32'(instr_fetched), 32'(mem[m_pc]));

      if (fl) begin
        fl_cnt++;
        m_valid = 1'b0;
        m_got = 0;
        wait_cnt = 0;
        m_pc = 8'($urandom);
      end else begin
        if (acc) m_got++;
        if (exp_adv) begin
          adv_cnt++;
          m_valid   = 1'b1;
          m_instr   = mem[m_pc];
          m_two     = (m_len == 2);
          m_imm     = (m_len == 2) ? mem[8'(m_pc + 8'd1)] : 8'h00;
          m_pc_slot = m_pc;
          m_pc      = 8'(m_pc + 8'(m_len));
          m_got     = 0;
        end else if (rdy) begin
          m_valid = 1'b0;
        end
      end
    end
    step();
    chk("rnd_end_valid", 32'(id_valid), 32'(m_valid));
`ifdef FETCH_STATS_EN
    chk("stat_instr", 32'(stat_instr), 32'(adv_cnt));
    chk("stat_flush", 32'(stat_flush), 32'(fl_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage between the program-counter unit and decode.
- Reads instruction bytes for the PC presented by the PC unit over a byte-wide req/ack instruction-memory port.
- Assembles one-byte instructions, and two-byte instructions (opcode 0xC) with their immediate.
- Hands the result to decode through a registered valid/ready slot.
- Drives the PC unit's stall input and returns the fetched opcode byte so the PC unit can pick a +1 or +2 increment.

Parameters:
OPCODE_2B, 4'hC, value of instr[7:4] that marks a two-byte instruction
STAT_W, 16, width of the statistics counters (only used with FETCH_STATS_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
pc_in  in  8  current PC from the PC unit
flush  in  1  branch taken or interrupt redirect; kills in-flight and buffered work
imem_req  out  1  instruction-memory read request
imem_addr  out  8  instruction-memory byte address
imem_rdata  in  8  read data; valid only when imem_ack=1
imem_ack  in  1  read completes this cycle
fetch_stall  out  1  to PC unit stall input; 0 only in the advance cycle
instr_fetched  out  8  opcode byte delivered in the advance cycle, else op_q
id_valid  out  1  decode slot holds an instruction
id_ready  in  1  decode accepts the slot this cycle
id_instr  out  8  opcode byte
id_imm  out  8  immediate byte; 8'h00 for one-byte instructions
id_two_byte  out  1  slot holds a two-byte instruction
id_pc  out  8  address of the opcode byte

Behaviour:
- Reset (rst_n=0, async): state=S_OP; id_valid=0; id_instr=id_imm=id_pc=0; id_two_byte=0; op_q=imm_q=0.
- After reset deasserts, imem_req rises in the first S_OP cycle.
- slot_free = !id_valid | id_ready.
- advance = the cycle in which an instruction is written into the decode slot. fetch_stall = !advance. The PC unit moves only in the advance cycle, so pc_in is stable across S_OP/S_IMM/S_HOLD.
- S_OP:
  - imem_req=1, imem_addr=pc_in.
  - On ack: if rdata[7:4]==OPCODE_2B, capture op_q and go to S_IMM.
  - On ack with a one-byte opcode: if slot_free, advance (instr_fetched=rdata) and stay in S_OP; otherwise capture op_q and go to S_HOLD.
- S_IMM:
  - imem_req=1, imem_addr=pc_in+1, modulo 256 (0xFF wraps to 0x00).
  - On ack: capture imm_q. Advance if slot_free and return to S_OP; otherwise go to S_HOLD.
- S_HOLD: imem_req=0; wait for slot_free, then advance from op_q/imm_q and go to S_OP.
- Advance loads id_instr, id_imm, id_two_byte, id_pc=pc_in and sets id_valid=1.
- id_valid clears on id_ready when no advance occurs in the same cycle.
- One instruction latency minimum: ack in cycle N → id_valid=1 at N+1 (one-byte) or after the second ack (two-byte).
- Memory-port rules:
  - imem_req is held until ack.
  - Wait-states of any length are allowed.
  - imem_addr stays stable while req=1.
- flush=1:
  - Has priority over everything: no advance that cycle, and any ack that cycle is discarded.
  - id_valid=0 at the next edge; state goes to S_OP.
  - imem_req=0 during the flush cycle.
  - The outstanding request is abandoned; memory must tolerate a dropped request.
- Flush while id_valid=1 and id_ready=1: the decode handshake completes, but no new load occurs.
- rst_n asserted mid-operation (any state) gives the reset values immediately; any partial two-byte fetch is lost.

Optional Feature:
FETCH_STATS_EN
- When defined, adds outputs stat_instr [STAT_W-1:0] (advance count) and stat_flush [STAT_W-1:0] (flush cycles).
- Both counters saturate at all-ones and reset to 0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- One-byte instruction: pc_in=0x10, mem[0x10]=0x35, ack after 1 wait cycle, id_ready=1 → fetch_stall=0 for exactly one cycle with instr_fetched=0x35. Next cycle: id_valid=1, id_instr=0x35, id_imm=0x00, id_pc=0x10, id_two_byte=0.
- Two-byte instruction: pc_in=0x20, mem=0xC1,0x7F → imem_addr 0x20 then 0x21; advance with instr_fetched=0xC1. Slot then holds id_instr=0xC1, id_imm=0x7F, id_two_byte=1.
- Backpressure: id_valid=1, id_ready=0, next opcode acked → S_HOLD, imem_req=0, fetch_stall=1, slot unchanged. Raise id_ready → advance in that cycle.
- Flush in S_IMM together with ack → no advance; id_valid=0 next cycle; imem_req=1, imem_addr=new pc_in the cycle after.
- Address wrap: pc_in=0xFF, mem[0xFF]=0xC2, mem[0x00]=0x11 → second request to 0x00, id_imm=0x11.
- Async reset asserted in S_IMM between edges → id_valid=0 without waiting for a clock edge. After release: S_OP, imem_req=1, addr=pc_in. With FETCH_STATS_EN defined, both counters read 0.
